// File: rtl/ram_ctrl.sv
// Word-addressed on-chip RAM controller: one load/store at a time with LAT wait cycles.
// Define RAM_CTRL_CYCLE_COUNT_EN to timestamp TOHOST stores on tohost_cycles.
module ram_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned LAT         = 2,
  parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        ram_ren,
  input  logic        ram_wen,
  input  logic [31:0] ram_addr,
  input  logic [31:0] ram_store,
  output logic [31:0] ram_load,
  output logic [1:0]  ram_state,
  output logic        tohost_valid,
  output logic [31:0] tohost_data,
  output logic [31:0] tohost_cycles
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt, cnt_nxt;
  logic                    lat_en;
  logic [31:0]             addr_p0;
  logic [DATA_W-1:0]       wdata_p0;
  logic                    wr_p0;
  logic [ADDR_WIDTH-1:0]   mem_idx;
  logic                    req, bad_req, same_req, wr_fire, th_hit;
  logic [DATA_W-1:0]       mem [DEPTH];

  assign req      = ram_ren | ram_wen;
  assign bad_req  = (ram_ren & ram_wen) | (ram_addr[1:0] != 2'b00) |
                    ((ram_addr >> (ADDR_WIDTH + 2)) != 32'd0);
  // A waiting request must keep its address and direction, else it is abandoned.
  assign same_req = (ram_addr == addr_p0) &
                    (wr_p0 ? (ram_wen & ~ram_ren) : (ram_ren & ~ram_wen));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    lat_en    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          if (bad_req) begin
            state_nxt = S_ERR;
          end else begin
            lat_en    = 1'b1;
            cnt_nxt   = CNT_INIT;
            state_nxt = (LAT > 0) ? S_WAIT : S_DONE;
          end
        end
      end
      S_WAIT: begin
        if (!same_req)          state_nxt = S_IDLE;
        else if (cnt == 4'd0)   state_nxt = S_DONE;
        else                    cnt_nxt   = cnt - 4'd1;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture stage: address, data and direction held for WAIT/DONE
  always_ff @(posedge clk) begin
    if (lat_en) begin
      addr_p0  <= ram_addr;
      wdata_p0 <= ram_store;
      wr_p0    <= ram_wen;
    end
  end

  // Access stage: memory read/write from the captured request
  assign mem_idx = addr_p0[ADDR_WIDTH+1:2];
  assign wr_fire = (state == S_DONE) & wr_p0;
  assign th_hit  = wr_fire & (addr_p0 == TOHOST_ADDR);

  always_ff @(posedge clk) begin
    if (wr_fire) mem[mem_idx] <= wdata_p0;
  end

  assign ram_load     = ((state == S_DONE) && !wr_p0) ? mem[mem_idx] : '0;
  assign ram_state    = state;
  assign tohost_valid = th_hit;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)       tohost_data <= '0;
    else if (th_hit) tohost_data <= wdata_p0;
  end

`ifdef RAM_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt;
  logic [31:0] cyc_cap;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cyc_cnt <= '0;
      cyc_cap <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (th_hit) cyc_cap <= cyc_cnt;
    end
  end

  assign tohost_cycles = cyc_cap;
`else
  assign tohost_cycles = '0;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl: LAT=2 instance driven by directed and random
// transactions, plus a LAT=0 instance for the zero-latency path.
module tb_ram_ctrl;
  localparam int          AW   = 14;
  localparam int          LATV = 2;
  localparam logic [31:0] TH   = 32'h0000_1000;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic        nrst;
  logic        ram_ren, ram_wen;
  logic [31:0] ram_addr, ram_store, ram_load, tohost_data, tohost_cycles;
  logic [1:0]  ram_state;
  logic        tohost_valid;

  logic        ram_ren0, ram_wen0;
  logic [31:0] ram_addr0, ram_store0, ram_load0, tohost_data0, tohost_cycles0;
  logic [1:0]  ram_state0;
  logic        tohost_valid0;

  ram_ctrl #(.ADDR_WIDTH(AW), .LAT(LATV), .TOHOST_ADDR(TH)) dut (
    .clk(tb_clk), .nrst(nrst), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_addr(ram_addr), .ram_store(ram_store), .ram_load(ram_load),
    .ram_state(ram_state), .tohost_valid(tohost_valid),
    .tohost_data(tohost_data), .tohost_cycles(tohost_cycles));

  ram_ctrl #(.ADDR_WIDTH(AW), .LAT(0), .TOHOST_ADDR(TH)) dut0 (
    .clk(tb_clk), .nrst(nrst), .ram_ren(ram_ren0), .ram_wen(ram_wen0),
    .ram_addr(ram_addr0), .ram_store(ram_store0), .ram_load(ram_load0),
    .ram_state(ram_state0), .tohost_valid(tohost_valid0),
    .tohost_data(tohost_data0), .tohost_cycles(tohost_cycles0));

  typedef struct {
    logic [1:0]  st;
    logic [31:0] load;
    logic        tv;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] model_th;
  logic [31:0] bench_cyc;
  logic [31:0] exp_cyc;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge tb_clk or negedge nrst) begin
    if (!nrst) bench_cyc <= 32'd0;
    else       bench_cyc <= bench_cyc + 32'd1;
  end

  // Monitor: every ACCESS/ERROR cycle consumes one expected response
  always @(negedge tb_clk) begin
    if (nrst === 1'b1) begin
      if (ram_state == 2'b10 || ram_state == 2'b11) begin
        if (sbq.size() == 0) begin
          chk("unexpected_response", 32'(ram_state), 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          chk("resp_state", 32'(ram_state), 32'(mon_e.st));
          chk("resp_load", ram_load, mon_e.load);
          chk("resp_tohost_valid", 32'(tohost_valid), 32'(mon_e.tv));
        end
      end else begin
        chk("quiet_load", ram_load, 32'd0);
        chk("quiet_tohost_valid", 32'(tohost_valid), 32'd0);
      end
    end
  end

  task automatic txn(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   err, fin;
    int   busy;
    err    = (r && w) || (a % 4 != 0) || (a >= (32'd1 << (AW + 2)));
    e.st   = err ? 2'b11 : 2'b10;
    e.load = (!err && r) ? model_mem[a] : 32'd0;
    e.tv   = !err && w && (a == TH);
    sbq.push_back(e);
    if (!err && w) begin
      model_mem[a] = d;
      if (a == TH) model_th = d;
    end
    @(posedge tb_clk); #1;
    ram_ren = r; ram_wen = w; ram_addr = a; ram_store = d;
    @(negedge tb_clk);
    chk("txn_idle_state", 32'(ram_state), 32'd0);
    busy = 0;
    fin  = 0;
    for (int i = 0; i < 40 && !fin; i++) begin
      @(negedge tb_clk);
      if (ram_state == 2'b01) busy++;
      else begin
        fin = 1;
        exp_cyc = bench_cyc;
      end
    end
    chk("txn_final_state", 32'(ram_state), 32'(e.st));
    chk("txn_busy_cycles", 32'(busy), err ? 32'd0 : 32'(LATV));
    @(posedge tb_clk); #1;
    ram_ren = 1'b0; ram_wen = 1'b0;
    @(negedge tb_clk);
    chk("txn_after_state", 32'(ram_state), 32'd0);
    chk("tohost_data", tohost_data, model_th);
    if (e.tv) begin
`ifdef RAM_CTRL_CYCLE_COUNT_EN
      chk("tohost_cycles", tohost_cycles, exp_cyc);
`else
      chk("tohost_cycles", tohost_cycles, 32'd0);
`endif
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "timeout");
  end

  logic [31:0] pool [8];
  logic [31:0] ra, rd;
  int          k;
  bit          seen;

  initial begin
    pool = '{32'h0, 32'h4, 32'h10, 32'h20, 32'h30, 32'h40, 32'hFFFC, TH};
    model_th = 32'd0;
    nrst = 1'b0;
    ram_ren = 0; ram_wen = 0; ram_addr = 0; ram_store = 0;
    ram_ren0 = 0; ram_wen0 = 0; ram_addr0 = 0; ram_store0 = 0;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk) nrst = 1'b1;
    repeat (5) begin
      @(negedge tb_clk);
      chk("rst_state", 32'(ram_state), 32'd0);
      chk("rst_load", ram_load, 32'd0);
      chk("rst_tohost_valid", 32'(tohost_valid), 32'd0);
      chk("rst_tohost_data", tohost_data, 32'd0);
    end

    txn(0, 1, 32'h10, 32'hDEADBEEF);
    txn(1, 0, 32'h10, 32'h0);
    txn(0, 1, 32'h20, 32'h11223344);
    txn(1, 0, 32'h13, 32'h0);
    txn(1, 1, 32'h20, 32'h99);
    txn(1, 0, 32'h0001_0000, 32'h0);
    txn(1, 0, 32'h20, 32'h0);

    // Write abandoned after the first BUSY cycle
    @(posedge tb_clk); #1;
    ram_wen = 1; ram_addr = 32'h20; ram_store = 32'h55;
    @(negedge tb_clk) chk("abort_idle", 32'(ram_state), 32'd0);
    @(negedge tb_clk) chk("abort_busy1", 32'(ram_state), 32'd1);
    @(posedge tb_clk); #1 ram_wen = 0;
    @(negedge tb_clk) chk("abort_busy2", 32'(ram_state), 32'd1);
    @(negedge tb_clk) chk("abort_free", 32'(ram_state), 32'd0);
    @(negedge tb_clk) chk("abort_stay_free", 32'(ram_state), 32'd0);
    txn(1, 0, 32'h20, 32'h0);

    txn(0, 1, TH, 32'd1);
    txn(0, 1, TH, 32'd7);
    txn(0, 1, TH + 32'd2, 32'd3);
    txn(0, 1, 32'hFFFC, 32'h0BADF00D);
    txn(1, 0, 32'hFFFC, 32'h0);
    txn(0, 1, 32'h30, 32'hCAFEF00D);

    // Reset in the middle of a write's BUSY phase
    @(posedge tb_clk); #1;
    ram_wen = 1; ram_addr = 32'h30; ram_store = 32'h12345678;
    @(negedge tb_clk);
    @(negedge tb_clk) chk("rstbusy_busy", 32'(ram_state), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("rstbusy_state", 32'(ram_state), 32'd0);
    chk("rstbusy_load", ram_load, 32'd0);
    chk("rstbusy_tohost_valid", 32'(tohost_valid), 32'd0);
    chk("rstbusy_tohost_data", tohost_data, 32'd0);
    chk("rstbusy_tohost_cycles", tohost_cycles, 32'd0);
    ram_wen = 0;
    model_th = 32'd0;
    @(posedge tb_clk);
    @(negedge tb_clk) nrst = 1'b1;
    txn(1, 0, 32'h30, 32'h0);

    // Reset during the ACCESS cycle of a TOHOST store
    sbq.push_back('{st: 2'b10, load: 32'd0, tv: 1'b1});
    @(posedge tb_clk); #1;
    ram_wen = 1; ram_addr = TH; ram_store = 32'd9;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge tb_clk);
      if (ram_state == 2'b10) seen = 1;
    end
    chk("rstdone_reached_access", 32'(seen), 32'd1);
    #1 nrst = 1'b0;
    #1;
    chk("rstdone_tohost_valid", 32'(tohost_valid), 32'd0);
    chk("rstdone_state", 32'(ram_state), 32'd0);
    ram_wen = 0;
    @(posedge tb_clk);
    @(negedge tb_clk) nrst = 1'b1;
    txn(1, 0, TH, 32'h0);

    for (int n = 0; n < 60; n++) begin
      k  = $urandom_range(0, 9);
      ra = pool[$urandom_range(0, 7)];
      rd = $urandom;
      if (k == 0)                            txn(1, 0, ra | 32'($urandom_range(1, 3)), 32'h0);
      else if (k == 1)                       txn(0, 1, ra | (32'h1 << $urandom_range(16, 31)), rd);
      else if (k == 2)                       txn(1, 1, ra, rd);
      else if (k < 6 && model_mem.exists(ra)) txn(1, 0, ra, 32'h0);
      else                                   txn(0, 1, ra, rd);
    end

    // Zero-latency instance
    @(posedge tb_clk); #1;
    ram_wen0 = 1; ram_addr0 = 32'h4; ram_store0 = 32'hA5A5A5A5;
    @(negedge tb_clk) chk("lat0_wr_idle", 32'(ram_state0), 32'd0);
    @(negedge tb_clk);
    chk("lat0_wr_access", 32'(ram_state0), 32'd2);
    chk("lat0_wr_load", ram_load0, 32'd0);
    @(posedge tb_clk); #1 ram_wen0 = 0;
    @(negedge tb_clk) chk("lat0_wr_free", 32'(ram_state0), 32'd0);
    @(posedge tb_clk); #1;
    ram_ren0 = 1;
    @(negedge tb_clk) chk("lat0_rd_idle", 32'(ram_state0), 32'd0);
    @(negedge tb_clk);
    chk("lat0_rd_access", 32'(ram_state0), 32'd2);
    chk("lat0_rd_load", ram_load0, 32'hA5A5A5A5);
    chk("lat0_tohost_valid", 32'(tohost_valid0), 32'd0);
    @(posedge tb_clk); #1 ram_ren0 = 0;
    @(negedge tb_clk) chk("lat0_rd_free", 32'(ram_state0), 32'd0);

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
Name: ram_ctrl

Overview:
- Word-addressed on-chip memory controller downstream of the core's system RAM interface (ram_ren/ram_wen/ram_addr/ram_store -> ram_load/ram_state).
- Services one load or store at a time with a programmable access latency.
- Reports a status on ram_state and flags completed stores to the TOHOST address so benches and the synthesized top can detect test completion.

Parameters:
- ADDR_WIDTH, 14, log2 of memory depth in 32-bit words (64 KiB default).
- LAT, 2, wait cycles spent in BUSY before ACCESS; legal range 0..15.
- TOHOST_ADDR, 32'h0000_1000, byte address whose completed store raises tohost_valid.

Ports:
- clk  in  1  system clock, rising-edge.
- nrst  in  1  asynchronous active-low reset.
- ram_ren  in  1  read request, held until ACCESS or ERROR.
- ram_wen  in  1  write request, held until ACCESS or ERROR.
- ram_addr  in  32  byte address.
- ram_store  in  32  write data.
- ram_load  out  32  read data, valid only while ram_state==ACCESS on a read.
- ram_state  out  2  00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR.
- tohost_valid  out  1  one-cycle pulse on a completed store to TOHOST_ADDR.
- tohost_data  out  32  last value stored to TOHOST_ADDR (sticky).
- tohost_cycles  out  32  cycle count at TOHOST store (see Optional Feature).

Behaviour:
- Reset (nrst low, asynchronous):
  - FSM goes to IDLE.
  - ram_state=FREE; ram_load=0; tohost_valid=0; tohost_data=0; tohost_cycles=0.
  - Memory array is not cleared.
- FSM states: IDLE, WAIT, DONE, ERR.
- IDLE (ram_state=FREE). A request (ren|wen) is checked and moves the FSM as follows:
  - ren&wen both high, ram_addr[1:0]!=0, or ram_addr[31:ADDR_WIDTH+2]!=0 -> ERR.
  - Else LAT>0 -> WAIT, latching addr, store data, op, and a counter set to LAT-1.
  - Else (LAT==0) -> DONE.
- WAIT (ram_state=BUSY):
  - Counter decrements each cycle; at 0 -> DONE.
  - If the request drops or ram_addr/op differs from the latched value -> IDLE (abort, no write).
- DONE (ram_state=ACCESS), exactly one cycle:
  - Read: ram_load=mem[addr[ADDR_WIDTH+1:2]] combinationally from the latched address.
  - Write: mem is updated at the rising edge ending DONE.
  - Next state is always IDLE.
  - A request still held in IDLE is a new transaction; the requester must drop or change it after seeing ACCESS.
- ERR (ram_state=ERROR), one cycle, no memory side effect, -> IDLE.
- ram_load is 0 whenever ram_state!=ACCESS or the op is a write.
- TOHOST: a write whose DONE cycle has latched addr==TOHOST_ADDR:
  - Performs the normal memory write.
  - Asserts tohost_valid during that DONE cycle.
  - Loads tohost_data at the ending edge.
  - A misaligned or aborted store never pulses.
- Back-to-back: the minimum transaction is LAT+2 cycles including the IDLE cycle. There is no pipelining.
- Reset asserted mid-WAIT or mid-DONE: no write occurs; tohost_valid drops immediately.

Optional Feature:
- Macro RAM_CTRL_CYCLE_COUNT_EN.
- Defined:
  - A 32-bit free-running counter clears on reset and increments every clk while nrst is high; it wraps at 2^32.
  - On each TOHOST store completion, tohost_cycles captures the counter value of that DONE cycle.
- Undefined: no counter is built; tohost_cycles is tied to 0.

Test Plan:
- Reset then idle -> ram_state=00, ram_load=0, tohost_valid=0, tohost_data=0 for 5 cycles.
- LAT=2: write 0xDEADBEEF @0x10, hold wen -> 2 cycles BUSY, 1 ACCESS. Then read @0x10 -> BUSY,BUSY,ACCESS with ram_load=0xDEADBEEF.
- Read @0x13, then ren&wen @0x20, then read @0x0001_0000 (ADDR_WIDTH=14) -> each gives one ERROR cycle then FREE. A follow-up read @0x20 returns the prior contents.
- Write 0x55 @0x20 with wen dropped after first BUSY cycle -> back to FREE, no ACCESS. A later read @0x20 shows the old value.
- Write 32'd1 to 0x1000 -> tohost_valid high exactly in the ACCESS cycle; tohost_data=1. Then write 32'd7 -> tohost_data=7. With RAM_CTRL_CYCLE_COUNT_EN, tohost_cycles equals the bench cycle count since reset release.
- LAT=0: write 0xA5A5A5A5 @0x4 -> FREE then ACCESS next cycle. Assert nrst low during a LAT=2 write's BUSY -> all outputs 0 immediately, and the address is unchanged afterwards.
